// File: rtl/music_voice_arbiter.sv
// music_voice_arbiter: beat timebase plus note-output arbiter between
// the melody sequencer and a set of fixed-priority sound-effect requesters.
module music_voice_arbiter #(
  parameter int N_SFX     = 4,
  parameter int NOTE_W    = 5,
  parameter int BEAT_DIV  = 5000000,
  parameter int SFX_BEATS = 4,
  parameter int REST_NOTE = 25,
  localparam int IW = (N_SFX > 1) ? $clog2(N_SFX) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NOTE_W-1:0]       melody_note,
  input  logic [N_SFX-1:0]        sfx_req,
  input  logic [N_SFX*NOTE_W-1:0] sfx_note,
  output logic                    melody_adv,
  output logic [N_SFX-1:0]        sfx_ack,
  output logic                    sfx_active,
  output logic [IW-1:0]           active_id,
  output logic [NOTE_W-1:0]       note_out
);

  localparam int CW = $clog2(BEAT_DIV + 1);
  localparam int BW = (SFX_BEATS > 1) ? $clog2(SFX_BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MELODY,
    SFX
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     beats_left;
  logic [N_SFX-1:0]  pending;
  logic [N_SFX-1:0]  elig;
  logic [N_SFX-1:0]  gmask;
  logic [IW-1:0]     gid;
  logic [NOTE_W-1:0] gnote;
  logic [NOTE_W-1:0] note_d;
  logic              tick;
  logic              any;
  logic              grant;
  logic              adv;

  // The ack pulse is visible while the requester still holds its level,
  // so it masks that request instead of re-queueing it.
  always_comb begin
    elig  = (pending | sfx_req) & ~sfx_ack;
    gmask = elig & (~elig + N_SFX'(1));
    any   = |elig;
    gid   = '0;
    for (int i = N_SFX - 1; i >= 0; i--) begin
      if (elig[i]) gid = IW'(i);
    end
    gnote = sfx_note[int'(gid)*NOTE_W +: NOTE_W];
    tick  = enable && (state != IDLE)
            && (cnt == CW'(BEAT_DIV));
  end

  always_comb begin
    nxt   = state;
    grant = 1'b0;
    adv   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) nxt = MELODY;
      end
      MELODY: begin
        if (!enable) begin
          nxt = IDLE;
        end else if (tick) begin
          if (any) begin
            grant = 1'b1;
            nxt   = SFX;
          end else begin
            adv = 1'b1;
          end
        end
      end
      SFX: begin
        if (!enable) begin
          nxt = IDLE;
        end else if (tick && beats_left == '0) begin
          if (any) begin
            grant = 1'b1;
          end else begin
            nxt = MELODY;
            adv = 1'b1;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    note_d = NOTE_W'(REST_NOTE);
    priority case (1'b1)
      grant:         note_d = gnote;
      nxt == MELODY: note_d = melody_note;
      nxt == SFX:    note_d = note_out;
      default:       note_d = NOTE_W'(REST_NOTE);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= CW'(1);
      pending    <= '0;
      beats_left <= '0;
      note_out   <= NOTE_W'(REST_NOTE);
      melody_adv <= 1'b0;
      sfx_ack    <= '0;
      sfx_active <= 1'b0;
      active_id  <= '0;
    end else begin
      state <= nxt;

      if (state == IDLE || !enable || tick) begin
        cnt <= CW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (state == IDLE || !enable) begin
        pending <= '0;
      end else begin
        pending <= elig & ~(grant ? gmask : '0);
      end

      if (nxt == IDLE) begin
        beats_left <= '0;
      end else if (grant) begin
        beats_left <= BW'(SFX_BEATS - 1);
      end else if (state == SFX && tick
                   && beats_left != '0) begin
        beats_left <= beats_left - BW'(1);
      end

      note_out   <= note_d;
      melody_adv <= adv;
      sfx_ack    <= grant ? gmask : '0;
      sfx_active <= (nxt == SFX);

      if (grant) begin
        active_id <= gid;
      end else if (nxt != SFX) begin
        active_id <= '0;
      end
    end
  end

endmodule

// File: tb/tb_music_voice_arbiter.sv
// tb_music_voice_arbiter: directed stimulus with a cycle-stamped
// scoreboard of expected melody_adv / sfx_ack events.
module tb_music_voice_arbiter;

  localparam int N = 4;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [W-1:0] melody_note;
  logic [N-1:0] sfx_req;
  logic [N*W-1:0] sfx_note;
  logic         melody_adv;
  logic [N-1:0] sfx_ack;
  logic         sfx_active;
  logic [1:0]   active_id;
  logic [W-1:0] note_out;

  typedef struct {
    int c;
    int adv;
    int ack;
    int id;
    int note;
  } ev_t;

  ev_t sbq[$];
  int  cyc  = 0;
  int  nvec = 0;
  int  nerr = 0;
  int  mprev;

  music_voice_arbiter #(
    .N_SFX(N),
    .NOTE_W(W),
    .BEAT_DIV(4),
    .SFX_BEATS(2),
    .REST_NOTE(25)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .melody_note(melody_note),
    .sfx_req(sfx_req),
    .sfx_note(sfx_note),
    .melody_adv(melody_adv),
    .sfx_ack(sfx_ack),
    .sfx_active(sfx_active),
    .active_id(active_id),
    .note_out(note_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push_adv(int c);
    sbq.push_back('{c, 1, 0, 0, 0});
  endtask

  task automatic push_ack(int c, int id, int note);
    sbq.push_back('{c, 0, 1 << id, id, note});
  endtask

  task automatic goto(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_note(int i, logic [W-1:0] n);
    sfx_note[i*W +: W] = n;
  endtask

  // Monitor: every adv/ack pulse must match the oldest expected event.
  always @(negedge clk) begin
    ev_t e;
    while (sbq.size() > 0 && sbq[0].c < cyc) begin
      nvec++;
      nerr++;
      $display("FAIL missed_event: expected at cycle %0d, still absent at %0d",
               sbq[0].c, cyc);
      void'(sbq.pop_front());
    end
    if (melody_adv || sfx_ack != '0) begin
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_event: cycle %0d adv=%b ack=%b, none expected",
                 cyc, melody_adv, sfx_ack);
      end else begin
        e = sbq.pop_front();
        chk("event_cycle", cyc, e.c);
        chk("melody_adv", 32'(melody_adv), e.adv);
        chk("sfx_ack", 32'(sfx_ack), e.ack);
        if (e.adv != 0) begin
          chk("adv_sfx_active", 32'(sfx_active), 0);
        end else begin
          chk("ack_active_id", 32'(active_id), e.id);
          chk("ack_note_out", 32'(note_out), e.note);
          chk("ack_sfx_active", 32'(sfx_active), 1);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    melody_note = '0;
    sfx_req     = '0;
    sfx_note    = '0;

    goto(2);
    chk("rst_note_out", 32'(note_out), 25);
    chk("rst_melody_adv", 32'(melody_adv), 0);
    chk("rst_sfx_ack", 32'(sfx_ack), 0);
    chk("rst_sfx_active", 32'(sfx_active), 0);
    chk("rst_active_id", 32'(active_id), 0);
    goto(3);
    rst_n = 1'b1;
    goto(5);
    chk("idle_note_out", 32'(note_out), 25);
    chk("idle_sfx_active", 32'(sfx_active), 0);

    // Melody only: MELODY from cycle 7, ticks every 4 cycles.
    goto(6);
    enable      = 1'b1;
    mprev       = 1;
    melody_note = W'(mprev);
    push_adv(11);
    push_adv(15);
    push_adv(19);
    push_adv(23);
    push_adv(27);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("melody_follow", 32'(note_out), mprev);
      mprev       = (i * 3 + 2) % 24;
      melody_note = W'(mprev);
    end
    melody_note = 5'd3;

    // Single effect requested mid-beat.
    goto(28);
    set_note(0, 5'd7);
    set_note(1, 5'd20);
    set_note(2, 5'd10);
    set_note(3, 5'd12);
    sfx_req[2] = 1'b1;
    push_ack(31, 2, 10);
    push_adv(39);
    push_adv(43);
    goto(31);
    sfx_req[2] = 1'b0;
    goto(34);
    chk("sfx2_note_mid", 32'(note_out), 10);
    chk("sfx2_active_mid", 32'(sfx_active), 1);
    chk("sfx2_id_mid", 32'(active_id), 2);
    goto(38);
    chk("sfx2_note_last", 32'(note_out), 10);
    goto(39);
    chk("resume_note", 32'(note_out), 3);

    // Two simultaneous requests chain without a melody beat.
    goto(44);
    sfx_req[0] = 1'b1;
    sfx_req[3] = 1'b1;
    push_ack(47, 0, 7);
    push_ack(55, 3, 12);
    push_adv(63);
    push_adv(67);
    goto(47);
    sfx_req[0] = 1'b0;
    goto(51);
    chk("chain_id0_note", 32'(note_out), 7);
    goto(55);
    sfx_req[3] = 1'b0;
    goto(59);
    chk("chain_id3_note", 32'(note_out), 12);
    chk("chain_id3_id", 32'(active_id), 3);

    // Request first seen on the tick edge itself.
    goto(70);
    sfx_req[1] = 1'b1;
    push_ack(71, 1, 20);
    push_adv(79);
    goto(71);
    sfx_req[1] = 1'b0;

    // Enable drop during beat 1 aborts the effect and pending.
    goto(80);
    set_note(2, 5'd9);
    sfx_req[2] = 1'b1;
    push_ack(83, 2, 9);
    goto(83);
    sfx_req[2] = 1'b0;
    set_note(3, 5'd14);
    sfx_req[3] = 1'b1;
    goto(84);
    chk("abort_pre_note", 32'(note_out), 9);
    chk("abort_pre_active", 32'(sfx_active), 1);
    enable     = 1'b0;
    sfx_req[3] = 1'b0;
    goto(85);
    chk("abort_note_out", 32'(note_out), 25);
    chk("abort_sfx_active", 32'(sfx_active), 0);
    chk("abort_active_id", 32'(active_id), 0);
    chk("abort_sfx_ack", 32'(sfx_ack), 0);
    goto(87);
    enable = 1'b1;
    push_adv(92);
    push_adv(96);
    goto(88);
    chk("reenable_note", 32'(note_out), 3);

    // Asynchronous reset between edges during an effect.
    goto(97);
    set_note(0, 5'd5);
    sfx_req[0] = 1'b1;
    push_ack(100, 0, 5);
    goto(100);
    sfx_req[0] = 1'b0;
    goto(101);
    chk("prereset_active", 32'(sfx_active), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_note_out", 32'(note_out), 25);
    chk("async_sfx_active", 32'(sfx_active), 0);
    chk("async_active_id", 32'(active_id), 0);
    chk("async_sfx_ack", 32'(sfx_ack), 0);
    chk("async_melody_adv", 32'(melody_adv), 0);
    enable = 1'b0;
    goto(103);
    rst_n = 1'b1;
    goto(108);
    chk("post_reset_note", 32'(note_out), 25);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
